sram_axi_arbiter: RTL and testbench
===================================

SRAM_AXI_ARBITER -- requirements
Module: sram_axi_arbiter

Interface
REQ-001 Parameter NPORT, default 2: number of SRAM-like request ports, legal range 1..8.
REQ-002 Parameter ID_W, default 4: width of the AXI ID fields; SHALL be at least clog2(NPORT).
REQ-003 aclk  in  1  sole clock; all state updates on rising edge.
REQ-004 aresetn  in  1  reset, synchronous and active-low.
REQ-005 req / wr  in  NPORT each  per-port request valid / write select (1 = write).
REQ-006 size  in  2*NPORT  per-port size: 0 = byte, 1 = half, 2 = word.
REQ-007 addr / wdata  in  32*NPORT each  per-port byte address / write data.
REQ-008 addr_ok / data_ok  out  NPORT each  per-port request accepted / response complete (one-cycle pulses).
REQ-009 rdata  out  32*NPORT  per-port registered read data, valid with data_ok.
REQ-010 AXI3 master channels ar*, r*, aw*, w*, b*: 32-bit data and address, ID_W-bit ids, standard widths (len 4, size 3, burst 2, lock 2, cache 4, prot 3, strb 4).

Function
REQ-011 Read and write paths SHALL be independent; each holds at most one outstanding transaction.
REQ-012 Read FSM: R_IDLE -> R_AR on read grant; R_AR -> R_R on arvalid&arready; R_R -> R_IDLE on rvalid&rready.
REQ-013 Write FSM: W_IDLE -> W_AW on write grant; aw and w handshakes tracked by separate done flags, in any order; W_AW -> W_B once both are done; W_B -> W_IDLE on bvalid&bready.
REQ-014 Arbitration: round-robin per path over ports whose req=1 and whose wr matches the path; search starts at last-granted index + 1, mod NPORT.
REQ-015 Only the read path SHALL arbitrate when its FSM is R_IDLE; only the write path when its FSM is W_IDLE.
REQ-016 addr_ok[i] SHALL be combinational, high in the grant cycle only; address, size, wdata and port index are latched on that edge.
REQ-017 Hazard rule: a read SHALL NOT be granted while the write FSM is not W_IDLE and the latched write addr[31:2] equals the candidate addr[31:2]; that port is skipped in that cycle.
REQ-018 Hazard rule: the write path SHALL NOT issue a new grant in the cycle it would be granted to the same port as the read path.
REQ-019 arid / awid / wid SHALL equal the latched port index; arlen = awlen = 0; arburst = awburst = 2'b01; lock, cache and prot = 0; arsize = awsize = {1'b0, size}.
REQ-020 wstrb: size 0 -> 4'b0001 << addr[1:0]; size 1 -> addr[1] ? 4'b1100 : 4'b0011; size 2 -> 4'b1111. wlast = 1.
REQ-021 arvalid is high only in R_AR. awvalid is high in W_AW until aw is done; wvalid is high in W_AW until w is done.
REQ-022 rready is high only in R_R; bready is high only in W_B.
REQ-023 On rvalid&rready, rdata[port] <= AXI rdata and data_ok[port] pulses the next cycle.
REQ-024 On bvalid&bready, data_ok[port] pulses the next cycle.
REQ-025 Read and write data_ok to different ports MAY coincide; they are never to the same port (REQ-018).
REQ-026 A returned rid or bid that does not match the latched index SHALL be ignored; the FSM holds.
REQ-027 rresp and bresp are ignored.
REQ-028 Latency: grant at cycle 0, arvalid high at cycle 1. With arready at cycle 1 and rvalid at cycle 2, data_ok is at cycle 3.

Reset
REQ-029 While aresetn=0 at a clock edge: both FSMs -> IDLE; done flags cleared; round-robin pointers -> NPORT-1 (so port 0 wins first).
REQ-030 While aresetn=0 at a clock edge: all valid/ready outputs, addr_ok, data_ok and rdata -> 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction without a data_ok pulse; AXI outputs are low from the cycle after the reset edge.

Verification
REQ-032 Port 0 reads word 0x1FC00000 with a slave rdata of 0xDEADBEEF -> addr_ok[0] in the same cycle; data_ok[0]=1 and rdata[31:0]=0xDEADBEEF at cycle 3 (zero-wait slave).
REQ-033 Port 1 writes half 0xABCD to 0x80000006 -> awaddr=0x80000006, awsize=1, wstrb=4'b1100, awid=wid=1, data_ok[1] after bvalid.
REQ-034 Ports 0 and 1 both request reads continuously -> grants alternate 0,1,0,1; arid follows the grant order.
REQ-035 Write to 0x100 is pending in W_B while another port reads 0x102 -> read is not granted until the cycle after the write completes; a read of 0x200 is granted immediately.
REQ-036 awready delayed 3 cycles with wready immediate -> wvalid drops after 1 cycle, awvalid is held, and the FSM enters W_B only after both handshakes.
REQ-037 aresetn=0 asserted while in R_R -> arvalid, rready and data_ok stay 0; the next read after reset is granted to port 0.

Source files
------------

// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter
//   Bridges NPORT SRAM-like request ports onto one AXI3 master. Reads and
//   writes are handled by independent paths, each with one outstanding
//   transaction and its own round-robin arbiter.
//
//   Ports
//     aclk, aresetn        clock, synchronous active-low reset
//     req, wr, size        per-port request valid, write select, size (0/1/2)
//     addr, wdata          per-port byte address and write data (32 bits each)
//     addr_ok              per-port combinational grant pulse
//     data_ok, rdata       per-port completion pulse and registered read data
//     ar*, r*, aw*, w*, b* AXI3 master channels (axi_rdata / axi_wdata are the
//                          AXI data buses, renamed to avoid the per-port names)
module sram_axi_arbiter #(
    parameter int NPORT = 2,
    parameter int ID_W  = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NPORT-1:0]     req,
    input  logic [NPORT-1:0]     wr,
    input  logic [2*NPORT-1:0]   size,
    input  logic [32*NPORT-1:0]  addr,
    input  logic [32*NPORT-1:0]  wdata,
    output logic [NPORT-1:0]     addr_ok,
    output logic [NPORT-1:0]     data_ok,
    output logic [32*NPORT-1:0]  rdata,
    output logic [ID_W-1:0]      arid,
    output logic [31:0]          araddr,
    output logic [3:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic [1:0]           arlock,
    output logic [3:0]           arcache,
    output logic [2:0]           arprot,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [ID_W-1:0]      rid,
    input  logic [31:0]          axi_rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [ID_W-1:0]      awid,
    output logic [31:0]          awaddr,
    output logic [3:0]           awlen,
    output logic [2:0]           awsize,
    output logic [1:0]           awburst,
    output logic [1:0]           awlock,
    output logic [3:0]           awcache,
    output logic [2:0]           awprot,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [ID_W-1:0]      wid,
    output logic [31:0]          axi_wdata,
    output logic [3:0]           wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [ID_W-1:0]      bid,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_t;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;

    logic [31:0]    addr_a  [NPORT];
    logic [31:0]    wdata_a [NPORT];
    logic [1:0]     size_a  [NPORT];
    logic [31:0]    rdata_q [NPORT];

    logic [PW-1:0]  r_last, w_last, r_sel, w_sel, r_port, w_port;
    logic           r_found, w_found, r_grant, w_grant;
    logic [NPORT-1:0] rd_cand, wr_cand;
    logic [31:0]    r_addr, w_addr, w_data;
    logic [1:0]     r_size, w_size;
    logic           aw_done, w_done, aw_fin, w_fin;
    logic           rid_match, bid_match;
    logic           unused_inputs;

    assign unused_inputs = ^{rresp, rlast, bresp};

    always_comb begin
        for (int unsigned i = 0; i < NPORT; i++) begin
            addr_a[i]  = addr[32*i +: 32];
            wdata_a[i] = wdata[32*i +: 32];
            size_a[i]  = size[2*i +: 2];
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            rdata[32*i +: 32] = rdata_q[i];
        end
    end

    // A read whose word matches the in-flight write is held back so it cannot
    // overtake the write on the bus.
    always_comb begin
        rd_cand = '0;
        wr_cand = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            rd_cand[i] = req[i] & ~wr[i] &
                         ~((w_state != W_IDLE) && (w_addr[31:2] == addr_a[i][31:2]));
            wr_cand[i] = req[i] & wr[i];
        end
    end

    // Round-robin: search starts one past the last granted index.
    always_comb begin
        r_found = 1'b0;
        w_found = 1'b0;
        r_sel   = r_last;
        w_sel   = w_last;
        for (int unsigned k = 1; k <= NPORT; k++) begin
            if (!r_found && rd_cand[PW'((32'(r_last) + k) % NPORT)]) begin
                r_found = 1'b1;
                r_sel   = PW'((32'(r_last) + k) % NPORT);
            end
            if (!w_found && wr_cand[PW'((32'(w_last) + k) % NPORT)]) begin
                w_found = 1'b1;
                w_sel   = PW'((32'(w_last) + k) % NPORT);
            end
        end
    end

    assign r_grant = aresetn && (r_state == R_IDLE) && r_found;
    assign w_grant = aresetn && (w_state == W_IDLE) && w_found &&
                     !(r_grant && (r_sel == w_sel));

    always_comb begin
        addr_ok = '0;
        if (r_grant) addr_ok[r_sel] = 1'b1;
        if (w_grant) addr_ok[w_sel] = 1'b1;
    end

    assign rid_match = (rid == ID_W'(r_port));
    assign bid_match = (bid == ID_W'(w_port));

    // AXI channel drive
    assign arid    = ID_W'(r_port);
    assign araddr  = r_addr;
    assign arlen   = '0;
    assign arsize  = {1'b0, r_size};
    assign arburst = 2'b01;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign arvalid = (r_state == R_AR);
    assign rready  = (r_state == R_R);

    assign awid    = ID_W'(w_port);
    assign awaddr  = w_addr;
    assign awlen   = '0;
    assign awsize  = {1'b0, w_size};
    assign awburst = 2'b01;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign awvalid = (w_state == W_AW) && !aw_done;
    assign wid       = ID_W'(w_port);
    assign axi_wdata = w_data;
    assign wlast     = 1'b1;
    assign wvalid    = (w_state == W_AW) && !w_done;
    assign bready    = (w_state == W_B);

    always_comb begin
        case (w_size)
            2'd0:    wstrb = 4'b0001 << w_addr[1:0];
            2'd1:    wstrb = w_addr[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    // Each write handshake counts as done either from its flag or from this cycle.
    assign aw_fin = aw_done | (awvalid & awready);
    assign w_fin  = w_done  | (wvalid & wready);

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (r_grant) r_next = R_AR;
            R_AR:    if (arready) r_next = R_R;
            R_R:     if (rvalid && rid_match) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (w_grant) w_next = W_AW;
            W_AW:    if (aw_fin && w_fin) w_next = W_B;
            W_B:     if (bvalid && bid_match) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            r_last  <= PW'(NPORT - 1);
            w_last  <= PW'(NPORT - 1);
            r_port  <= '0;
            w_port  <= '0;
            r_addr  <= '0;
            w_addr  <= '0;
            w_data  <= '0;
            r_size  <= '0;
            w_size  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            data_ok <= '0;
            for (int unsigned i = 0; i < NPORT; i++) rdata_q[i] <= '0;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
            data_ok <= '0;
            if (r_grant) begin
                r_port <= r_sel;
                r_last <= r_sel;
                r_addr <= addr_a[r_sel];
                r_size <= size_a[r_sel];
            end
            if (w_grant) begin
                w_port  <= w_sel;
                w_last  <= w_sel;
                w_addr  <= addr_a[w_sel];
                w_size  <= size_a[w_sel];
                w_data  <= wdata_a[w_sel];
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
            if ((r_state == R_R) && rvalid && rid_match) begin
                rdata_q[r_port] <= axi_rdata;
                data_ok[r_port] <= 1'b1;
            end
            if ((w_state == W_B) && bvalid && bid_match) begin
                data_ok[w_port] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// tb_sram_axi_arbiter
//   Directed bench for sram_axi_arbiter (NPORT=2, ID_W=4). The AXI slave is
//   driven cycle by cycle from the tasks; outputs are sampled 2-3 time units
//   after the rising edge.
module tb_sram_axi_arbiter;

    logic        aclk, aresetn;
    logic [1:0]  req, wr;
    logic [3:0]  size;
    logic [63:0] addr, wdata;
    logic [1:0]  addr_ok, data_ok;
    logic [63:0] rdata;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, axi_rdata, axi_wdata;
    logic [3:0]  arlen, arcache, awlen, awcache, wstrb;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int errors = 0;

    sram_axi_arbiter #(.NPORT(2), .ID_W(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .req(req), .wr(wr), .size(size),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .axi_rdata(axi_rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .axi_wdata(axi_wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d);
        req[p] = r;
        wr[p] = w;
        size[p*2 +: 2] = sz;
        addr[p*32 +: 32] = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic clear_inputs();
        req = '0; wr = '0; size = '0; addr = '0; wdata = '0;
        arready = 0; rid = '0; axi_rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 0;
        awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_inputs();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        clear_inputs();
        set_port(0, 1, 0, 2'd2, 32'h0000_0010, 32'h0);
        tick();
        tick();
        #1;
        checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin errors++; $display("FAIL rst_valids got %b exp 00000", {arvalid, awvalid, wvalid, rready, bready}); end
        checks++; if (addr_ok !== 2'b00) begin errors++; $display("FAIL rst_addr_ok got %b exp 00", addr_ok); end
        checks++; if (data_ok !== 2'b00) begin errors++; $display("FAIL rst_data_ok got %b exp 00", data_ok); end
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
        clear_inputs();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_read_latency();
        set_port(0, 1, 0, 2'd2, 32'h1FC0_0000, 32'h0);
        #1;
        checks++; if (addr_ok !== 2'b01) begin errors++; $display("FAIL rd_addr_ok got %b exp 01", addr_ok); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rd_arvalid_c0 got %b exp 0", arvalid); end
        tick();
        set_port(0, 0, 0, 2'd0, 32'h0, 32'h0);
        arready = 1;
        #1;
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rd_arvalid_c1 got %b exp 1", arvalid); end
        checks++; if (araddr !== 32'h1FC0_0000) begin errors++; $display("FAIL rd_araddr got %h exp 1fc00000", araddr); end
        checks++; if ({arid, arsize, arlen, arburst} !== {4'd0, 3'd2, 4'd0, 2'b01}) begin errors++; $display("FAIL rd_ar_fields got %h/%h/%h/%h exp 0/2/0/1", arid, arsize, arlen, arburst); end
        checks++; if ({arlock, arcache, arprot} !== 9'b0) begin errors++; $display("FAIL rd_ar_attr got %h exp 0", {arlock, arcache, arprot}); end
        tick();
        arready = 0; rvalid = 1; rid = 4'd0; axi_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL rd_c2_arv_rr got %b exp 01", {arvalid, rready}); end
        tick();
        rvalid = 0;
        #1;
        checks++; if (data_ok !== 2'b01) begin errors++; $display("FAIL rd_data_ok_c3 got %b exp 01", data_ok); end
        checks++; if (rdata[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata got %h exp deadbeef", rdata[31:0]); end
        tick();
        checks++; if (data_ok !== 2'b00) begin errors++; $display("FAIL rd_data_ok_c4 got %b exp 00", data_ok); end
    endtask

    task automatic test_write_half();
        set_port(1, 1, 1, 2'd1, 32'h8000_0006, 32'h0000_ABCD);
        #1;
        checks++; if (addr_ok !== 2'b10) begin errors++; $display("FAIL wh_addr_ok got %b exp 10", addr_ok); end
        tick();
        set_port(1, 0, 0, 2'd0, 32'h0, 32'h0);
        awready = 1; wready = 1;
        #1;
        checks++; if ({awvalid, wvalid, wlast} !== 3'b111) begin errors++; $display("FAIL wh_valids got %b exp 111", {awvalid, wvalid, wlast}); end
        checks++; if (awaddr !== 32'h8000_0006) begin errors++; $display("FAIL wh_awaddr got %h exp 80000006", awaddr); end
        checks++; if ({awsize, wstrb} !== {3'd1, 4'b1100}) begin errors++; $display("FAIL wh_size_strb got %h/%b exp 1/1100", awsize, wstrb); end
        checks++; if ({awid, wid} !== {4'd1, 4'd1}) begin errors++; $display("FAIL wh_ids got %h/%h exp 1/1", awid, wid); end
        checks++; if (axi_wdata !== 32'h0000_ABCD) begin errors++; $display("FAIL wh_wdata got %h exp 0000abcd", axi_wdata); end
        checks++; if ({awlen, awburst} !== {4'd0, 2'b01}) begin errors++; $display("FAIL wh_len_burst got %h/%h exp 0/1", awlen, awburst); end
        tick();
        awready = 0; wready = 0; bvalid = 1; bid = 4'd1;
        #1;
        checks++; if ({awvalid, wvalid, bready, data_ok} !== 5'b00100) begin errors++; $display("FAIL wh_b_phase got %b exp 00100", {awvalid, wvalid, bready, data_ok}); end
        tick();
        bvalid = 0;
        #1;
        checks++; if (data_ok !== 2'b10) begin errors++; $display("FAIL wh_data_ok got %b exp 10", data_ok); end
        tick();
    endtask

    task automatic test_strobes();
        logic [1:0]  sv [4];
        logic [31:0] av [4];
        logic [3:0]  ev [4];
        sv[0] = 2'd0; av[0] = 32'h0000_1001; ev[0] = 4'b0010;
        sv[1] = 2'd0; av[1] = 32'h0000_1003; ev[1] = 4'b1000;
        sv[2] = 2'd1; av[2] = 32'h0000_1000; ev[2] = 4'b0011;
        sv[3] = 2'd2; av[3] = 32'h0000_1004; ev[3] = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            set_port(0, 1, 1, sv[i], av[i], 32'h1234_5678);
            #1;
            checks++; if (addr_ok !== 2'b01) begin errors++; $display("FAIL strb%0d_addr_ok got %b exp 01", i, addr_ok); end
            tick();
            set_port(0, 0, 0, 2'd0, 32'h0, 32'h0);
            awready = 1; wready = 1;
            #1;
            checks++; if ({awsize, wstrb, awid} !== {1'b0, sv[i], ev[i], 4'd0}) begin errors++; $display("FAIL strb%0d got size %h strb %b id %h exp size %h strb %b id 0", i, awsize, wstrb, awid, sv[i], ev[i]); end
            tick();
            awready = 0; wready = 0; bvalid = 1; bid = 4'd0;
            tick();
            bvalid = 0;
            #1;
            checks++; if (data_ok !== 2'b01) begin errors++; $display("FAIL strb%0d_data_ok got %b exp 01", i, data_ok); end
            tick();
        end
    endtask

    task automatic test_id_mismatch();
        set_port(0, 1, 0, 2'd2, 32'h0000_0040, 32'h0);
        tick();
        set_port(0, 0, 0, 2'd0, 32'h0, 32'h0);
        arready = 1;
        tick();
        arready = 0; rvalid = 1; rid = 4'd1; axi_rdata = 32'h1111_1111;
        #1;
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL idm_rready got %b exp 1", rready); end
        tick();
        rid = 4'd0; axi_rdata = 32'h2222_2222;
        #1;
        checks++; if ({data_ok, rready} !== 3'b001) begin errors++; $display("FAIL idm_ignored got %b exp 001", {data_ok, rready}); end
        tick();
        rvalid = 0;
        #1;
        checks++; if (data_ok !== 2'b01) begin errors++; $display("FAIL idm_data_ok got %b exp 01", data_ok); end
        checks++; if (rdata[31:0] !== 32'h2222_2222) begin errors++; $display("FAIL idm_rdata got %h exp 22222222", rdata[31:0]); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ok;
        do_reset();
        set_port(0, 1, 0, 2'd2, 32'h0000_1000, 32'h0);
        set_port(1, 1, 0, 2'd2, 32'h0000_2000, 32'h0);
        arready = 1;
        for (int k = 0; k < 4; k++) begin
            exp_ok = 2'b01 << (k % 2);
            #1;
            checks++; if (addr_ok !== exp_ok) begin errors++; $display("FAIL rr%0d_grant got %b exp %b", k, addr_ok, exp_ok); end
            tick();
            #1;
            checks++; if ({arvalid, arid} !== {1'b1, 4'(k % 2)}) begin errors++; $display("FAIL rr%0d_arid got %b/%h exp 1/%0d", k, arvalid, arid, k % 2); end
            tick();
            rvalid = 1; rid = 4'(k % 2); axi_rdata = 32'hA0 + 32'(k);
            tick();
            rvalid = 0;
            #1;
            checks++; if (data_ok !== exp_ok) begin errors++; $display("FAIL rr%0d_data_ok got %b exp %b", k, data_ok, exp_ok); end
            checks++; if (rdata[(k % 2)*32 +: 32] !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL rr%0d_rdata got %h exp %h", k, rdata[(k % 2)*32 +: 32], 32'hA0 + 32'(k)); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_hazard();
        do_reset();
        set_port(1, 1, 1, 2'd2, 32'h0000_0100, 32'h55);
        #1;
        checks++; if (addr_ok !== 2'b10) begin errors++; $display("FAIL hz_wr_grant got %b exp 10", addr_ok); end
        tick();
        set_port(1, 0, 0, 2'd0, 32'h0, 32'h0);
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        set_port(0, 1, 0, 2'd2, 32'h0000_0102, 32'h0);
        #1;
        checks++; if ({addr_ok, bready} !== 3'b001) begin errors++; $display("FAIL hz_block_wb got %b exp 001", {addr_ok, bready}); end
        tick();
        bvalid = 1; bid = 4'd1;
        #1;
        checks++; if (addr_ok !== 2'b00) begin errors++; $display("FAIL hz_block_bvalid got %b exp 00", addr_ok); end
        tick();
        bvalid = 0;
        #1;
        checks++; if ({addr_ok, data_ok} !== 4'b0110) begin errors++; $display("FAIL hz_release got %b exp 0110", {addr_ok, data_ok}); end
        tick();
        set_port(0, 0, 0, 2'd0, 32'h0, 32'h0);
        arready = 1;
        tick();
        arready = 0; rvalid = 1; rid = 4'd0;
        tick();
        rvalid = 0;
        tick();
        set_port(1, 1, 1, 2'd2, 32'h0000_0100, 32'h66);
        #1;
        checks++; if (addr_ok !== 2'b10) begin errors++; $display("FAIL hz_wr2_grant got %b exp 10", addr_ok); end
        tick();
        set_port(1, 0, 0, 2'd0, 32'h0, 32'h0);
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        set_port(0, 1, 0, 2'd2, 32'h0000_0200, 32'h0);
        #1;
        checks++; if (addr_ok !== 2'b01) begin errors++; $display("FAIL hz_no_conflict got %b exp 01", addr_ok); end
        tick();
        set_port(0, 0, 0, 2'd0, 32'h0, 32'h0);
        arready = 1; bvalid = 1; bid = 4'd1;
        tick();
        arready = 0; bvalid = 0; rvalid = 1; rid = 4'd0;
        #1;
        checks++; if (data_ok !== 2'b10) begin errors++; $display("FAIL hz_wr2_data_ok got %b exp 10", data_ok); end
        tick();
        rvalid = 0;
        tick();
    endtask

    task automatic test_aw_delay();
        do_reset();
        set_port(1, 1, 1, 2'd2, 32'h0000_0300, 32'h77);
        #1;
        checks++; if (addr_ok !== 2'b10) begin errors++; $display("FAIL awd_grant got %b exp 10", addr_ok); end
        tick();
        set_port(1, 0, 0, 2'd0, 32'h0, 32'h0);
        wready = 1; awready = 0;
        #1;
        checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL awd_c1 got %b exp 11", {awvalid, wvalid}); end
        tick();
        #1;
        checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin errors++; $display("FAIL awd_c2 got %b exp 100", {awvalid, wvalid, bready}); end
        tick();
        #1;
        checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin errors++; $display("FAIL awd_c3 got %b exp 100", {awvalid, wvalid, bready}); end
        tick();
        awready = 1;
        #1;
        checks++; if ({awvalid, bready} !== 2'b10) begin errors++; $display("FAIL awd_c4 got %b exp 10", {awvalid, bready}); end
        tick();
        awready = 0; wready = 0; bvalid = 1; bid = 4'd1;
        #1;
        checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL awd_wb got %b exp 001", {awvalid, wvalid, bready}); end
        tick();
        bvalid = 0;
        #1;
        checks++; if (data_ok !== 2'b10) begin errors++; $display("FAIL awd_data_ok got %b exp 10", data_ok); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_port(0, 1, 0, 2'd2, 32'h0000_0500, 32'h0);
        tick();
        set_port(0, 0, 0, 2'd0, 32'h0, 32'h0);
        arready = 1;
        tick();
        arready = 0; rvalid = 1; rid = 4'd0; axi_rdata = 32'h9999_9999;
        aresetn = 1'b0;
        tick();
        #1;
        checks++; if ({arvalid, rready, data_ok} !== 4'b0) begin errors++; $display("FAIL rm_c1 got %b exp 0000", {arvalid, rready, data_ok}); end
        tick();
        #1;
        checks++; if ({arvalid, rready, data_ok} !== 4'b0) begin errors++; $display("FAIL rm_c2 got %b exp 0000", {arvalid, rready, data_ok}); end
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL rm_rdata got %h exp 0", rdata); end
        aresetn = 1'b1; rvalid = 0;
        set_port(0, 1, 0, 2'd2, 32'h0000_0600, 32'h0);
        set_port(1, 1, 0, 2'd2, 32'h0000_0700, 32'h0);
        #1;
        checks++; if (addr_ok !== 2'b01) begin errors++; $display("FAIL rm_first_grant got %b exp 01", addr_ok); end
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_half();
        test_strobes();
        test_id_mismatch();
        test_round_robin();
        test_hazard();
        test_aw_delay();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
